eth_tx_sched: RTL and testbench



---
 rtl/eth_tx_sched_if.sv | 22 ++
 rtl/eth_tx_sched.sv | 148 ++++++++++++++
 tb/tb_eth_tx_sched.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_sched_if.sv
// Handshake bundle between the frame sources / MAC TX and the transmit scheduler.
// The slave side is the scheduler; the master side drives requests, tx_done and the timer tick.
interface eth_tx_sched_if;
  logic [2:0] req;
  logic       tx_done;
  logic       timer_pulse;
  logic [2:0] grant;
  logic [1:0] mux_sel;
  logic       busy;
  logic       arp_gen_req;
  logic       timeout_err;

  modport master (
    output req, tx_done, timer_pulse,
    input  grant, mux_sel, busy, arp_gen_req, timeout_err
  );

  modport slave (
    input  req, tx_done, timer_pulse,
    output grant, mux_sel, busy, arp_gen_req, timeout_err
  );
endinterface

// File: rtl/eth_tx_sched.sv
// Round-robin TX scheduler for ARP/ICMP/UDP frames with inter-frame gap,
// grant timeout and periodic ARP request triggering. All outputs registered.
module eth_tx_sched #(
  parameter int unsigned ARP_PERIOD     = 4,
  parameter int unsigned TIMEOUT_PULSES = 2,
  parameter int unsigned IFG_CYCLES     = 12
) (
  input  logic           tx_clk,
  input  logic           rst,
  eth_tx_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GRANT, IFG} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] arp_cnt_q, arp_cnt_d;
  logic [3:0] to_cnt_q, to_cnt_d;
  logic [7:0] ifg_cnt_q, ifg_cnt_d;

  logic [2:0] grant_q, grant_d;
  logic [1:0] mux_q, mux_d;
  logic       busy_q, busy_d;
  logic       arp_q, arp_d;
  logic       to_err_q, to_err_d;

  logic       sel_valid;
  logic [1:0] sel_idx;
  logic [1:0] cand;
  logic       arp_fire;
  logic       abort;

  // First requester at or after the rotating pointer, wrapping 2 -> 0.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      cand = 2'((32'(ptr_q) + k) % 3);
      if (!sel_valid && bus.req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      arp_cnt_q <= '0;
      to_cnt_q  <= '0;
      ifg_cnt_q <= '0;
      grant_q   <= '0;
      mux_q     <= '0;
      busy_q    <= 1'b0;
      arp_q     <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      arp_cnt_q <= arp_cnt_d;
      to_cnt_q  <= to_cnt_d;
      ifg_cnt_q <= ifg_cnt_d;
      grant_q   <= grant_d;
      mux_q     <= mux_d;
      busy_q    <= busy_d;
      arp_q     <= arp_d;
      to_err_q  <= to_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    arp_cnt_d = arp_cnt_q;
    to_cnt_d  = to_cnt_q;
    ifg_cnt_d = ifg_cnt_q;
    arp_fire  = 1'b0;
    abort     = 1'b0;

    if (bus.timer_pulse) begin
      if (arp_cnt_q == 8'(ARP_PERIOD - 1)) begin
        arp_cnt_d = '0;
        arp_fire  = 1'b1;
      end else begin
        arp_cnt_d = arp_cnt_q + 8'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d  = GRANT;
          ptr_d    = (sel_idx == 2'd2) ? 2'd0 : sel_idx + 2'd1;
          to_cnt_d = '0;
        end
      end
      GRANT: begin
        // tx_done has priority over a coincident final timeout pulse.
        if (bus.tx_done) begin
          state_d   = IFG;
          ifg_cnt_d = 8'(IFG_CYCLES - 1);
        end else if (bus.timer_pulse) begin
          if (to_cnt_q == 4'(TIMEOUT_PULSES - 1)) begin
            state_d   = IFG;
            ifg_cnt_d = 8'(IFG_CYCLES - 1);
            abort     = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 4'd1;
          end
        end
      end
      IFG: begin
        if (ifg_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          ifg_cnt_d = ifg_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values are derived from the upcoming state so they register on the same edge.
  always_comb begin
    grant_d  = '0;
    mux_d    = mux_q;
    busy_d   = (state_d != IDLE);
    arp_d    = arp_fire;
    to_err_d = abort;
    if (state_d == GRANT) begin
      if (state_q == IDLE) begin
        grant_d = 3'b001 << sel_idx;
        mux_d   = sel_idx;
      end else begin
        grant_d = grant_q;
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.mux_sel     = mux_q;
  assign bus.busy        = busy_q;
  assign bus.arp_gen_req = arp_q;
  assign bus.timeout_err = to_err_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Bench for eth_tx_sched: directed scenarios plus randomized traffic, checked
// every cycle against an ownership/countdown model of the scheduling rules.
module tb_eth_tx_sched;
  localparam int ARP_P = 4;
  localparam int TO_P  = 2;
  localparam int IFG_P = 12;

  logic tx_clk = 1'b0;
  logic rst    = 1'b1;

  eth_tx_sched_if bus();

  eth_tx_sched #(
    .ARP_PERIOD     (ARP_P),
    .TIMEOUT_PULSES (TO_P),
    .IFG_CYCLES     (IFG_P)
  ) dut (
    .tx_clk (tx_clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  always #4 tx_clk = ~tx_clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: who owns the transmitter, how many gap cycles remain, pulses seen in this grant.
  int m_owner = -1;
  int m_mux = 0, m_ptr = 0, m_ifg = 0, m_pulses = 0, m_arp_total = 0, m_idx = 0;
  int e_grant = 0, e_busy = 0, e_arp = 0, e_to = 0;

  always @(posedge tx_clk) begin
    if (rst) begin
      m_owner = -1; m_mux = 0; m_ptr = 0; m_ifg = 0; m_pulses = 0; m_arp_total = 0;
      e_arp = 0; e_to = 0;
    end else begin
      e_arp = 0;
      e_to  = 0;
      if (bus.timer_pulse) begin
        m_arp_total++;
        e_arp = ((m_arp_total % ARP_P) == 0) ? 1 : 0;
      end
      if (m_owner >= 0) begin
        if (bus.tx_done) begin
          m_owner = -1;
          m_ifg   = IFG_P;
        end else if (bus.timer_pulse) begin
          m_pulses++;
          if (m_pulses == TO_P) begin
            m_owner = -1;
            m_ifg   = IFG_P;
            e_to    = 1;
          end
        end
      end else if (m_ifg > 0) begin
        m_ifg--;
      end else if (bus.req != 3'b000) begin
        for (int k = 0; k < 3; k++) begin
          m_idx = (m_ptr + k) % 3;
          if (m_owner < 0 && bus.req[m_idx]) m_owner = m_idx;
        end
        m_mux    = m_owner;
        m_ptr    = (m_owner + 1) % 3;
        m_pulses = 0;
      end
    end
    e_grant = (m_owner >= 0) ? (1 << m_owner) : 0;
    e_busy  = (m_owner >= 0 || m_ifg > 0) ? 1 : 0;
  end

  always @(negedge tx_clk) begin
    if (chk_en) begin
      check("grant",       int'(bus.grant),       e_grant);
      check("mux_sel",     int'(bus.mux_sel),     m_mux);
      check("busy",        int'(bus.busy),        e_busy);
      check("arp_gen_req", int'(bus.arp_gen_req), e_arp);
      check("timeout_err", int'(bus.timeout_err), e_to);
    end
  end

  task automatic tick();
    @(posedge tx_clk);
    #1;
  endtask

  task automatic wait_busy_low(output int n);
    n = 0;
    while (bus.busy && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (bus.grant == 3'b000 && n < 300) begin
      tick();
      n++;
    end
  endtask

  logic [2:0] seq [4];
  logic [2:0] src;
  int n, arp_seen, done_wait;

  initial begin
    seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    bus.req = '0; bus.tx_done = 1'b0; bus.timer_pulse = 1'b0;
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    check("reset_grant", int'(bus.grant), 0);
    check("reset_busy",  int'(bus.busy),  0);
    tick();
    rst = 1'b0;

    // Basic grant, hold, release and gap length
    bus.req = 3'b001;
    tick();
    check("t1_grant", int'(bus.grant), 1);
    check("t1_mux",   int'(bus.mux_sel), 0);
    check("t1_busy",  int'(bus.busy), 1);
    check("t1_model_grant", e_grant, 1);
    repeat (7) tick();
    bus.tx_done = 1'b1; bus.req = '0;
    tick();
    bus.tx_done = 1'b0;
    check("t1_drop", int'(bus.grant), 0);
    check("t1_busy_ifg", int'(bus.busy), 1);
    wait_busy_low(n);
    check("t1_ifg_len", n, IFG_P);

    // Round-robin rotation with all sources requesting
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_grant(n);
      check("t2_seq", int'(bus.grant), int'(seq[i]));
      check("t2_gap", n, (i == 0) ? 1 : IFG_P + 1);
      repeat (4) tick();
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
    end
    bus.req = '0;
    wait_busy_low(n);

    // Timeout abort of a UDP grant
    bus.req = 3'b100;
    wait_grant(n);
    check("t3_grant", int'(bus.grant), 4);
    repeat (2) tick();
    bus.timer_pulse = 1'b1; tick(); bus.timer_pulse = 1'b0;
    check("t3_hold", int'(bus.grant), 4);
    repeat (2) tick();
    bus.timer_pulse = 1'b1; tick(); bus.timer_pulse = 1'b0;
    check("t3_abort_grant", int'(bus.grant), 0);
    check("t3_timeout", int'(bus.timeout_err), 1);
    check("t3_model_to", e_to, 1);
    bus.req = '0;
    tick();
    check("t3_timeout_1cyc", int'(bus.timeout_err), 0);
    wait_busy_low(n);

    // tx_done racing the final timeout pulse
    bus.req = 3'b010;
    wait_grant(n);
    check("t4_grant", int'(bus.grant), 2);
    tick();
    bus.timer_pulse = 1'b1; tick(); bus.timer_pulse = 1'b0;
    tick();
    bus.timer_pulse = 1'b1; bus.tx_done = 1'b1; bus.req = '0;
    tick();
    bus.timer_pulse = 1'b0; bus.tx_done = 1'b0;
    check("t4_drop", int'(bus.grant), 0);
    check("t4_no_timeout", int'(bus.timeout_err), 0);
    check("t4_busy", int'(bus.busy), 1);
    wait_busy_low(n);

    // Periodic ARP trigger while busy
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req = 3'b001;
    tick();
    arp_seen = 0;
    for (int i = 1; i <= 8; i++) begin
      repeat (2) tick();
      bus.timer_pulse = 1'b1; tick(); bus.timer_pulse = 1'b0;
      check("t5_arp", int'(bus.arp_gen_req), (i % 4 == 0) ? 1 : 0);
      if (bus.arp_gen_req) begin
        arp_seen++;
        check("t5_busy_at_arp", int'(bus.busy), 1);
      end
    end
    check("t5_arp_count", arp_seen, 2);
    bus.req = '0;
    bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
    wait_busy_low(n);

    // Reset mid-grant, pointer returns to ARP
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req = 3'b010;
    tick();
    check("t6_grant", int'(bus.grant), 2);
    tick();
    rst = 1'b1;
    tick();
    check("t6_rst_grant", int'(bus.grant), 0);
    check("t6_rst_busy",  int'(bus.busy), 0);
    check("t6_rst_mux",   int'(bus.mux_sel), 0);
    check("t6_rst_to",    int'(bus.timeout_err), 0);
    rst = 1'b0;
    bus.req = 3'b111;
    tick();
    check("t6_after_rst", int'(bus.grant), 1);
    bus.req = '0;
    bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
    wait_busy_low(n);

    // Randomized traffic
    src = '0;
    done_wait = -1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bus.tx_done = 1'b0;
      bus.timer_pulse = 1'b0;
      rst = 1'b0;
      if (bus.timeout_err && $urandom_range(1, 0) == 1) src[bus.mux_sel] = 1'b0;
      if (bus.grant != 3'b000) begin
        if (done_wait < 0) done_wait = int'($urandom_range(40, 0));
        if (done_wait == 0) begin
          bus.tx_done = 1'b1;
          src[bus.mux_sel] = 1'b0;
          done_wait = -1;
        end else begin
          done_wait--;
        end
      end else begin
        done_wait = -1;
        if ($urandom_range(19, 0) == 0) bus.tx_done = 1'b1;
      end
      for (int s = 0; s < 3; s++)
        if (!src[s] && $urandom_range(5, 0) == 0) src[s] = 1'b1;
      bus.req = src;
      if (bus.grant != 3'b000 && $urandom_range(7, 0) == 0) bus.req = src & ~bus.grant;
      if ($urandom_range(9, 0) == 0) bus.timer_pulse = 1'b1;
      if ($urandom_range(599, 0) == 0) begin
        rst = 1'b1;
        src = '0;
        done_wait = -1;
      end
      tick();
    end

    bus.req = '0; bus.tx_done = 1'b0; bus.timer_pulse = 1'b0; rst = 1'b0;
    tick();
    @(negedge tx_clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
